// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: IDLE/RUN/PAUSE/ADJUST state machine that produces the
// count-enable tick, clear/load strobes and adjust-mode blink for the counter path.
module stopwatch_ctrl #(
   parameter int TICK_DIV  = 100000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_run,
   input  logic       btn_clr,
   input  logic       adj,
   input  logic [1:0] sel,
   input  logic [3:0] num,
   output logic       tick_en,
   output logic       clr,
   output logic       load,
   output logic [1:0] load_sel,
   output logic [3:0] load_val,
   output logic       blink,
   output logic       paused,
   output logic [1:0] state
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSE  = 2'd2,
      ADJUST = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            runPrev_q, clrPrev_q;
   logic            runRise, clrRise;
   logic [TW-1:0]   tickCnt_q, tickCnt_d;
   logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
   logic            tick_q, tick_d;
   logic            clr_q, clr_d;
   logic            load_q, load_d;
   logic [1:0]      loadSel_q, loadSel_d;
   logic [3:0]      loadVal_q, loadVal_d;
   logic            blink_q, blink_d;
   logic            paused_q, paused_d;

   // Seconds-tens and minutes-tens digits only reach 5; ones digits reach 9.
   function automatic logic [3:0] clampDigit(input logic [1:0] s, input logic [3:0] v);
      logic [3:0] cap;
      cap = s[0] ? 4'd5 : 4'd9;
      return (v > cap) ? cap : v;
   endfunction

   assign runRise = btn_run & ~runPrev_q;
   assign clrRise = btn_clr & ~clrPrev_q;

   always_comb begin
      state_d   = state_q;
      clr_d     = 1'b0;
      load_d    = 1'b0;
      loadSel_d = loadSel_q;
      loadVal_d = loadVal_q;

      // adj dominates; inside adjust mode the buttons become clear and digit-commit.
      if (adj) begin
         state_d = ADJUST;
         if (clrRise) begin
            clr_d = 1'b1;
         end else if (runRise) begin
            load_d    = 1'b1;
            loadSel_d = sel;
            loadVal_d = clampDigit(sel, num);
         end
      end else if (clrRise) begin
         clr_d   = 1'b1;
         state_d = IDLE;
      end else if (state_q == ADJUST) begin
         state_d = PAUSE;
      end else if (runRise) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = state_q;
         endcase
      end

      // The divider only advances while counting, so a pause keeps the partial second.
      tickCnt_d = tickCnt_q;
      tick_d    = 1'b0;
      if (clr_d) begin
         tickCnt_d = '0;
      end else if (state_q == RUN) begin
         if (tickCnt_q == TICK_MAX) begin
            tickCnt_d = '0;
            tick_d    = 1'b1;
         end else begin
            tickCnt_d = tickCnt_q + TW'(1);
         end
      end

      blinkCnt_d = '0;
      blink_d    = 1'b0;
      if (state_d == ADJUST) begin
         if (state_q != ADJUST) begin
            blink_d = 1'b1;
         end else if (blinkCnt_q == BLINK_MAX) begin
            blink_d = ~blink_q;
         end else begin
            blinkCnt_d = blinkCnt_q + BW'(1);
            blink_d    = blink_q;
         end
      end

      paused_d = (state_d != RUN);
   end

   // Button history loads the live levels in reset so a held button yields no edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         runPrev_q  <= btn_run;
         clrPrev_q  <= btn_clr;
         tickCnt_q  <= '0;
         blinkCnt_q <= '0;
         tick_q     <= 1'b0;
         clr_q      <= 1'b0;
         load_q     <= 1'b0;
         loadSel_q  <= 2'd0;
         loadVal_q  <= 4'd0;
         blink_q    <= 1'b0;
         paused_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         runPrev_q  <= btn_run;
         clrPrev_q  <= btn_clr;
         tickCnt_q  <= tickCnt_d;
         blinkCnt_q <= blinkCnt_d;
         tick_q     <= tick_d;
         clr_q      <= clr_d;
         load_q     <= load_d;
         loadSel_q  <= loadSel_d;
         loadVal_q  <= loadVal_d;
         blink_q    <= blink_d;
         paused_q   <= paused_d;
      end
   end

   assign tick_en  = tick_q;
   assign clr      = clr_q;
   assign load     = load_q;
   assign load_sel = loadSel_q;
   assign load_val = loadVal_q;
   assign blink    = blink_q;
   assign paused   = paused_q;
   assign state    = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode sequencer for the stopwatch datapath. Takes debounced button levels and the adjust switches, and runs an IDLE/RUN/PAUSE/ADJUST state machine. Produces the count-enable tick, the clear and digit-load strobes, and the adjust-mode blink for the counter/display path. It replaces ad-hoc toggle logic clocked on button edges with a single-clock, fully synchronous controller.

Parameters:
TICK_DIV, 100000000, clk cycles per counting tick; must be ≥2.
BLINK_DIV, 25000000, clk cycles per blink half-period in ADJUST; must be ≥2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  synchronous active-low reset.
btn_run  in  1  debounced level; rising edge = start/pause, or commit in ADJUST.
btn_clr  in  1  debounced level; rising edge = clear.
adj  in  1  adjust-mode switch level.
sel  in  2  digit to adjust: 0=sec ones, 1=sec tens, 2=min ones, 3=min tens.
num  in  4  value to load.
tick_en  out  1  one-cycle count-enable pulse.
clr  out  1  one-cycle clear strobe to the counter.
load  out  1  one-cycle digit-load strobe.
load_sel  out  2  digit index qualified by load.
load_val  out  4  clamped digit value qualified by load.
blink  out  1  blink phase for the selected digit.
paused  out  1  high whenever state != RUN.
state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=ADJUST.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, tick_en/clr/load=0, load_sel=0, load_val=0, blink=0, paused=1.
  - Both dividers cleared.
  - Edge-detect history registers load the current btn_run/btn_clr levels, so a button held through reset produces no edge afterwards.
- Edge detect: rise = level & ~prev; prev updates every cycle.
- All outputs are registered.
  - The clr/load strobe appears in the cycle after the cycle in which the rise is sampled.
  - state changes at the same edge the strobe is registered.
- Transition priority per cycle: adj, then clr rise, then run rise.
  - adj=1 in any state: go to ADJUST. Clr and run rises are not state changes here; see ADJUST.
  - clr rise, adj=0: clr pulse, tick divider cleared, state goes to IDLE from any state.
  - run rise, adj=0, no clr rise: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - Simultaneous clr and run rise: the clr transition is taken and the run edge is dropped.
- ADJUST:
  - adj falling (adj=0 sampled) takes ADJUST→PAUSE.
  - clr rise: clr pulse, state stays ADJUST.
  - run rise: load=1 for one cycle with load_sel=sel and load_val=clamp(num), sampled in the rise cycle.
- Clamp: sel=1 or 3 caps at 5; sel=0 or 2 caps at 9. Values above the cap saturate to the cap.
- load_sel/load_val hold their last value when load=0.
- Tick divider (width = clog2(TICK_DIV)):
  - Increments only in RUN and holds its value in PAUSE/ADJUST, so the partial second is preserved.
  - At TICK_DIV-1 it wraps to 0 and tick_en=1 for the next cycle.
  - It is cleared on clr and on reset.
  - From a cleared divider, the first tick_en is TICK_DIV cycles after the RUN entry edge.
- Blink:
  - On entry to ADJUST, the blink counter clears and blink=1.
  - blink toggles every BLINK_DIV cycles while in ADJUST.
  - blink=0 in all other states.
- Reset mid-run aborts any pending strobe; no pulse is emitted in the reset cycle.

Test Plan:
- TICK_DIV=4, reset, then btn_run rise → state=1 next cycle; tick_en pulses every 4th cycle; paused=0.
- In RUN, 2 cycles after a tick, btn_run rise; hold PAUSE 10 cycles; btn_run rise again → no tick_en during PAUSE; first tick 2 cycles after re-entering RUN.
- In RUN, btn_clr and btn_run rise in the same cycle → clr=1 for one cycle; state=0; divider 0; no PAUSE.
- adj=1, sel=1, num=8, btn_run rise → load=1 for one cycle, load_sel=1, load_val=5. With sel=2, num=12 → load_val=9. Then adj=0 → state=2.
- BLINK_DIV=3 in ADJUST → blink pattern 1,1,1,0,0,0,1…; blink=0 after exit.
- Hold btn_run high through reset release → no state change and no strobes afterwards.
